// File: rtl/sync_ram_clr.sv
// sync_ram_clr: single-port synchronous RAM with a hardware clear sweep,
// optional output register stage and a read-valid strobe.
module sync_ram_clr #(
  parameter int unsigned        DATA_W  = 5,
  parameter int unsigned        DEPTH   = 4,
  parameter int unsigned        ADDR_W  = $clog2(DEPTH),
  parameter int unsigned        OUT_REG = 0,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              clr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                addr_ok_c;
  logic                mem_we_c;
  logic [ADDR_W-1:0]   mem_waddr_c;
  logic [DATA_W-1:0]   mem_wdata_c;
  logic                rd_req_c;
  logic [DATA_W-1:0]   rd_word_c;

  // Addresses beyond the last word only exist for non-power-of-2 depths.
  assign addr_ok_c = (32'(addr) < DEPTH);
  assign rd_word_c = addr_ok_c ? mem_q[addr] : CLR_VAL;

  // Next-state: clear sweep sequencing, request decode and first read stage.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = addr;
    mem_wdata_c = w_data;
    rd_req_c    = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = cnt_q;
        mem_wdata_c = CLR_VAL;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_READY: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          ready_d = 1'b0;
        end else if (en) begin
          if (wr) begin
            mem_we_c = addr_ok_c;
          end else begin
            rd_req_c = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase

    // Memory is left untouched while reset is held.
    if (rst) begin
      mem_we_c = 1'b0;
    end

    rd_vld_d  = rd_req_c;
    rd_data_d = rd_req_c ? rd_word_c : rd_data_q;
  end

  // Control and first read stage registers; reset restarts the sweep and flushes reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array, written by either the sweep or a request.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    // Second read stage: one extra cycle of latency, data held between reads.
    always_comb begin
      out_vld_d  = rd_vld_q;
      out_data_d = rd_vld_q ? rd_data_q : out_data_q;
    end

    // Output stage registers, flushed by reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_vld_q  <= 1'b0;
        out_data_q <= '0;
      end else begin
        out_vld_q  <= out_vld_d;
        out_data_q <= out_data_d;
      end
    end

    assign r_valid = out_vld_q;
    assign r_data  = out_data_q;
  end else begin : g_no_out_reg
    assign r_valid = rd_vld_q;
    assign r_data  = rd_data_q;
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_sync_ram_clr.sv
// Bench for sync_ram_clr: three instances (latency 1, latency 2, depth 5 with
// non-zero clear value), directed stimulus, queue scoreboard with a monitor.
module tb_sync_ram_clr;

  localparam int unsigned N = 3;

  typedef struct {
    logic [4:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_s      [N];
  logic       wr_s      [N];
  logic       clr_s     [N];
  logic       r_valid_s [N];
  logic       ready_s   [N];
  logic [2:0] addr_s    [N];
  logic [4:0] w_data_s  [N];
  logic [4:0] r_data_s  [N];

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sync_ram_clr #(.DATA_W(5), .DEPTH(4), .OUT_REG(0)) u_ram0 (
    .clk(clk), .rst(rst), .en(en_s[0]), .wr(wr_s[0]), .addr(addr_s[0][1:0]),
    .w_data(w_data_s[0]), .clr(clr_s[0]), .r_data(r_data_s[0]),
    .r_valid(r_valid_s[0]), .ready(ready_s[0])
  );

  sync_ram_clr #(.DATA_W(5), .DEPTH(4), .OUT_REG(1)) u_ram1 (
    .clk(clk), .rst(rst), .en(en_s[1]), .wr(wr_s[1]), .addr(addr_s[1][1:0]),
    .w_data(w_data_s[1]), .clr(clr_s[1]), .r_data(r_data_s[1]),
    .r_valid(r_valid_s[1]), .ready(ready_s[1])
  );

  sync_ram_clr #(.DATA_W(5), .DEPTH(5), .OUT_REG(0), .CLR_VAL(5'h03)) u_ram2 (
    .clk(clk), .rst(rst), .en(en_s[2]), .wr(wr_s[2]), .addr(addr_s[2]),
    .w_data(w_data_s[2]), .clr(clr_s[2]), .r_data(r_data_s[2]),
    .r_valid(r_valid_s[2]), .ready(ready_s[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic [4:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + ((i == 1) ? 2 : 1);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic wr_req(input int i, input logic [2:0] a, input logic [4:0] d);
    en_s[i] = 1'b1; wr_s[i] = 1'b1; addr_s[i] = a; w_data_s[i] = d;
    tick();
    en_s[i] = 1'b0; wr_s[i] = 1'b0;
  endtask

  task automatic rd_req(input int i, input logic [2:0] a, input logic [4:0] d);
    en_s[i] = 1'b1; wr_s[i] = 1'b0; addr_s[i] = a;
    push(i, d);
    tick();
    en_s[i] = 1'b0;
  endtask

  task automatic ready_seq(input int i);
    check($sformatf("clr_ready_low_dut%0d", i), 32'(ready_s[i]), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("clr_ready_dut%0d_k%0d", i, k), 32'(ready_s[i]), 32'(k == 4));
    end
  endtask

  // Monitor: every r_valid pulse must match the oldest expectation, data and cycle.
  task automatic mon_one(input int i);
    exp_t e;
    int   n;
    n = (i == 0) ? q0.size() : ((i == 1) ? q1.size() : q2.size());
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL unexpected_rvalid dut%0d: r_data=%0h at cycle %0d, none expected",
               i, r_data_s[i], cyc);
    end else begin
      case (i)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      if (r_data_s[i] !== e.data || cyc != e.cyc) begin
        errors++;
        $display("FAIL read_dut%0d: got %0h at cycle %0d, expected %0h at cycle %0d",
                 i, r_data_s[i], cyc, e.data, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (r_valid_s[i] === 1'b1) mon_one(i);
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      en_s[i] = 1'b0; wr_s[i] = 1'b0; clr_s[i] = 1'b0;
      addr_s[i] = '0; w_data_s[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_ready_dut%0d", i), 32'(ready_s[i]), 32'd0);
      check($sformatf("rst_rvalid_dut%0d", i), 32'(r_valid_s[i]), 32'd0);
      check($sformatf("rst_rdata_dut%0d", i), 32'(r_data_s[i]), 32'd0);
    end

    // Release reset: depth-4 parts ready after 4 edges, depth-5 after 5.
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("init_ready_dut0_k%0d", k), 32'(ready_s[0]), 32'(k >= 4));
      check($sformatf("init_ready_dut1_k%0d", k), 32'(ready_s[1]), 32'(k >= 4));
      check($sformatf("init_ready_dut2_k%0d", k), 32'(ready_s[2]), 32'(k >= 5));
    end

    // Everything reads back the clear value after the first sweep.
    for (int a = 0; a < 4; a++) rd_req(0, 3'(a), 5'h00);
    for (int a = 0; a < 4; a++) rd_req(1, 3'(a), 5'h00);
    for (int a = 0; a < 5; a++) rd_req(2, 3'(a), 5'h03);

    // Writes then back-to-back reads; write-then-read same address.
    wr_req(0, 3'd0, 5'h1F);
    wr_req(0, 3'd3, 5'h0A);
    rd_req(0, 3'd3, 5'h0A);
    rd_req(0, 3'd0, 5'h1F);
    wr_req(0, 3'd1, 5'h11);
    rd_req(0, 3'd1, 5'h11);

    // Output-registered instance: latency 2.
    wr_req(1, 3'd2, 5'h15);
    rd_req(1, 3'd2, 5'h15);
    tick();
    tick();

    // Out-of-range addresses on the depth-5 instance.
    wr_req(2, 3'd6, 5'h07);
    rd_req(2, 3'd6, 5'h03);
    wr_req(2, 3'd4, 5'h09);
    rd_req(2, 3'd4, 5'h09);
    rd_req(2, 3'd5, 5'h03);
    wr_req(2, 3'd7, 5'h1F);
    rd_req(2, 3'd7, 5'h03);
    rd_req(2, 3'd2, 5'h03);
    rd_req(2, 3'd3, 5'h03);

    // clr beats a same-cycle write; writes during the sweep are ignored.
    en_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 3'd2; w_data_s[0] = 5'h13; clr_s[0] = 1'b1;
    tick();
    clr_s[0] = 1'b0; addr_s[0] = 3'd1; w_data_s[0] = 5'h1E;
    ready_seq(0);
    en_s[0] = 1'b0; wr_s[0] = 1'b0;
    for (int a = 0; a < 4; a++) rd_req(0, 3'(a), 5'h00);

    // A read in flight when clr is accepted still returns pre-clear data.
    rd_req(1, 3'd2, 5'h15);
    clr_s[1] = 1'b1;
    tick();
    clr_s[1] = 1'b0;
    ready_seq(1);
    rd_req(1, 3'd2, 5'h00);

    // Reset during a sweep and with a read in flight.
    wr_req(0, 3'd3, 5'h0A);
    clr_s[0] = 1'b1;
    tick();
    clr_s[0] = 1'b0;
    en_s[1] = 1'b1; wr_s[1] = 1'b0; addr_s[1] = 3'd2;
    tick();
    en_s[1] = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_flush_rvalid_dut1", 32'(r_valid_s[1]), 32'd0);
    check("rst_mid_ready_dut2", 32'(ready_s[2]), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("rerst_ready_dut0_k%0d", k), 32'(ready_s[0]), 32'(k >= 4));
      check($sformatf("rerst_ready_dut2_k%0d", k), 32'(ready_s[2]), 32'(k >= 5));
    end
    for (int a = 0; a < 4; a++) rd_req(0, 3'(a), 5'h00);
    rd_req(2, 3'd4, 5'h03);
    rd_req(1, 3'd2, 5'h00);

    for (int k = 0; k < 4; k++) tick();
    check("drain_q0", 32'(q0.size()), 32'd0);
    check("drain_q1", 32'(q1.size()), 32'd0);
    check("drain_q2", 32'(q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
